// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement (magnitude converted, sign on neg).
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic                  neg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [BIN_W-1:0] shift_reg;
   logic [BIN_W-1:0] operand;
   logic [BCD_W-1:0] scratch;
   logic [BCD_W-1:0] corrected;
   logic [BCD_W-1:0] scratch_next;
   logic [CNT_W-1:0] count;
   logic             sticky_ovf;
   logic             top_bit;
   logic             accept;
   logic             last_shift;

   assign busy       = (state == SHIFT);
   assign done       = (state == DONE);
   assign accept     = (state != SHIFT) && start;
   assign last_shift = (state == SHIFT) && (count == CNT_W'(1));

   // All digits are corrected from their pre-shift values, so no digit sees another's +3.
   always_comb begin
      corrected = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            corrected[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
   end

   assign scratch_next = {corrected[BCD_W-2:0], shift_reg[BIN_W-1]};
   assign top_bit      = corrected[BCD_W-1];

`ifdef BIN2BCD_SIGNED_EN
   logic sign_lat;

   assign operand = bin_in[BIN_W-1] ? -bin_in : bin_in;

   // The sign rides along with the conversion and is published together with the digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_lat <= 1'b0;
         neg      <= 1'b0;
      end else begin
         if (accept)
            sign_lat <= bin_in[BIN_W-1];
         if (last_shift)
            neg <= sign_lat;
      end
   end
`else
   assign operand = bin_in;
   assign neg     = 1'b0;
`endif

   // Bits falling out of the top digit mean the value needs more than DIGITS digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         scratch    <= '0;
         count      <= '0;
         sticky_ovf <= 1'b0;
         bcd_out    <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  shift_reg  <= operand;
                  scratch    <= '0;
                  sticky_ovf <= 1'b0;
                  count      <= CNT_W'(BIN_W);
                  state      <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               scratch    <= scratch_next;
               shift_reg  <= {shift_reg[BIN_W-2:0], 1'b0};
               sticky_ovf <= sticky_ovf | top_bit;
               count      <= count - CNT_W'(1);
               if (last_shift) begin
                  bcd_out  <= scratch_next;
                  overflow <= sticky_ovf | top_bit;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three instances (8b/3d, 8b/2d, 16b/5d) against
// an arithmetic divide-by-ten reference model, honouring BIN2BCD_SIGNED_EN when defined.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b, start_c;
   logic [7:0]  bin_a, bin_b;
   logic [15:0] bin_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic        neg_a, neg_b, neg_c;
   logic [11:0] bcd_a;
   logic [7:0]  bcd_b;
   logic [19:0] bcd_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a), .busy(busy_a),
      .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .neg(neg_a));

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b), .busy(busy_b),
      .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .neg(neg_b));

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .bin_in(bin_c), .busy(busy_c),
      .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c), .neg(neg_c));

   function automatic int width_of(input int which);
      return (which == 2) ? 16 : 8;
   endfunction

   function automatic int digits_of(input int which);
      case (which)
         0:       return 3;
         1:       return 2;
         default: return 5;
      endcase
   endfunction

   function automatic logic [31:0] get_bcd(input int which);
      case (which)
         0:       return {20'd0, bcd_a};
         1:       return {24'd0, bcd_b};
         default: return {12'd0, bcd_c};
      endcase
   endfunction

   function automatic logic get_done(input int which);
      return (which == 0) ? done_a : (which == 1) ? done_b : done_c;
   endfunction

   function automatic logic get_busy(input int which);
      return (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
   endfunction

   function automatic logic get_ovf(input int which);
      return (which == 0) ? ovf_a : (which == 1) ? ovf_b : ovf_c;
   endfunction

   function automatic logic get_neg(input int which);
      return (which == 0) ? neg_a : (which == 1) ? neg_b : neg_c;
   endfunction

   task automatic set_start(input int which, input logic v);
      case (which)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic set_bin(input int which, input logic [31:0] v);
      case (which)
         0:       bin_a = v[7:0];
         1:       bin_b = v[7:0];
         default: bin_c = v[15:0];
      endcase
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: decimal digits by repeated division; anything left over is overflow.
   task automatic ref_model(input int which, input logic [31:0] val,
                            output logic [31:0] exp_bcd, output logic exp_ovf, output logic exp_neg);
      int     w   = width_of(which);
      longint mag = longint'(val) & ((longint'(1) << w) - 1);
      exp_neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      if (mag >= (longint'(1) << (w - 1))) begin
         exp_neg = 1'b1;
         mag     = (longint'(1) << w) - mag;
      end
`endif
      exp_bcd = '0;
      for (int i = 0; i < digits_of(which); i++) begin
         exp_bcd[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      exp_ovf = (mag != 0);
   endtask

   task automatic check_result(input int which, input logic [31:0] val, input int edges, input int exp_edges);
      logic [31:0] eb;
      logic        eo, en;
      ref_model(which, val, eb, eo, en);
      check_output($sformatf("latency u%0d v=%0h", which, val), edges, exp_edges);
      check_output($sformatf("bcd u%0d v=%0h", which, val), get_bcd(which), eb);
      check_output($sformatf("overflow u%0d v=%0h", which, val), get_ovf(which), eo);
      check_output($sformatf("neg u%0d v=%0h", which, val), get_neg(which), en);
      check_output($sformatf("busy_at_done u%0d", which), get_busy(which), 1'b0);
   endtask

   task automatic apply_stimulus(input int which, input logic [31:0] val,
                                 input bit poke_start, input bit release_rst);
      int edges = 0;
      int extra = 0;
      @(negedge clk);
      if (release_rst) rst = 1'b0;
      set_bin(which, val);
      set_start(which, 1'b1);
      @(negedge clk);
      set_start(which, 1'b0);
      set_bin(which, $urandom);
      check_output($sformatf("busy_after_accept u%0d", which), get_busy(which), 1'b1);
      while (edges < 64) begin
         if (poke_start && edges == 3) set_start(which, 1'b1);
         @(negedge clk);
         edges++;
         if (poke_start && edges == 4) set_start(which, 1'b0);
         if (get_done(which)) break;
      end
      check_result(which, val, edges, width_of(which));
      @(negedge clk);
      check_output($sformatf("done_single_pulse u%0d", which), get_done(which), 1'b0);
      if (poke_start) begin
         repeat (width_of(which) + 3) begin
            @(negedge clk);
            if (get_done(which)) extra++;
         end
         check_output("no_extra_done", extra, 0);
      end
   endtask

   initial begin
      int edges;
      int spurious;
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      bin_a = '0; bin_b = '0; bin_c = '0;
      repeat (2) @(negedge clk);
      check_output("reset busy", {busy_a, busy_b, busy_c}, 3'b000);
      check_output("reset done", {done_a, done_b, done_c}, 3'b000);
      check_output("reset bcd_a", get_bcd(0), 0);
      check_output("reset bcd_c", get_bcd(2), 0);
      check_output("reset ovf/neg", {ovf_a, ovf_b, ovf_c, neg_a, neg_b, neg_c}, 6'd0);
      rst = 1'b0;

      // Directed values from the 8b/3d, 8b/2d, 16b/5d and sign-handling cases.
      apply_stimulus(0, 255, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 99, 0, 0);
      apply_stimulus(0, 32'h80, 0, 0);
      apply_stimulus(0, 32'hFF, 0, 0);
      apply_stimulus(0, 32'h7F, 0, 0);
      apply_stimulus(1, 255, 0, 0);
      apply_stimulus(1, 99, 0, 0);
      apply_stimulus(2, 65535, 0, 0);
      apply_stimulus(2, 10000, 0, 0);

      // A start pulse mid-conversion must be ignored.
      apply_stimulus(0, 173, 1, 0);

      // Back-to-back: start held high across the done cycle.
      @(negedge clk);
      bin_a = 8'd200;
      start_a = 1'b1;
      @(negedge clk);
      edges = 0;
      while (edges < 64) begin
         @(negedge clk);
         edges++;
         if (done_a) break;
      end
      check_result(0, 200, edges, 8);
      bin_a = 8'd37;
      edges = 0;
      while (edges < 64) begin
         @(negedge clk);
         edges++;
         if (edges == 1) start_a = 1'b0;
         if (done_a) break;
      end
      check_result(0, 37, edges, 9);

      // Reset in the middle of a conversion aborts it without a done.
      @(negedge clk);
      bin_a = 8'd123;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort busy", busy_a, 1'b0);
      check_output("abort done", done_a, 1'b0);
      check_output("abort bcd_a", get_bcd(0), 0);
      check_output("abort bcd_c", get_bcd(2), 0);
      check_output("abort ovf/neg", {ovf_a, neg_a}, 2'b00);
      spurious = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_a || busy_a) spurious++;
      end
      check_output("abort quiet", spurious, 0);
      apply_stimulus(0, 42, 0, 1);

      // Randomized operands on every instance.
      for (int which = 0; which < 3; which++) begin
         for (int i = 0; i < 6; i++) begin
            apply_stimulus(which, $urandom, 0, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
